// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: FSM encoding for
// early branch resolution, the zero register number, and stall-need codes.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RESOLVE = 2'd2
   } br_state_e;

   typedef enum logic [1:0] {
      NEED_NONE = 2'd0,
      NEED_ONE  = 2'd1,
      NEED_TWO  = 2'd2
   } stall_need_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when destination r feeds a source the branch compares. $0 never
   // creates a dependency because it is hard-wired to zero.
   function automatic logic reg_match(input logic [4:0] r,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Inc,
   output logic [W-1:0] Q
);

   logic [W-1:0] q_q, q_d;

   // Next count: advance only when requested and not already saturated.
   always_comb begin
      q_d = q_q;
      if (Inc && (q_q != '1)) begin
         q_d = q_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge Clk) begin
      if (Rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign Q = q_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Early (ID-stage) branch resolution sequencer: classifies the data hazard of
// a branch against EX/MEM producers, stalls the front end for the required
// number of cycles, then resolves, redirects the PC and keeps statistics.
module branch_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             ID_Branch,
   input  logic             ID_Jump,
   input  logic             ID_UsesRt,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_WriteReg,
   input  logic             BranchTaken,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             PCSrcBranch,
   output logic [CNT_W-1:0] BranchCnt,
   output logic [CNT_W-1:0] TakenCnt,
   output logic [CNT_W-1:0] StallCnt
);

   br_state_e   state_q, state_d, state_eff;
   stall_need_e need;
   logic        ex_match, mem_match;
   logic        stall_cyc, resolve_cyc;

   assign ex_match  = reg_match(EX_WriteReg,  ID_Rs, ID_Rt, ID_UsesRt);
   assign mem_match = reg_match(MEM_WriteReg, ID_Rs, ID_Rt, ID_UsesRt);

   // Stall need of the branch in ID; a load in EX is the worst case.
   always_comb begin
      need = NEED_NONE;
      if (EX_MemRead && ex_match)        need = NEED_TWO;
      else if (EX_RegWrite && ex_match)  need = NEED_ONE;
      else if (MEM_MemRead && mem_match) need = NEED_ONE;
   end

   // Next-state and control decode; reset forces RUN decoding so outputs
   // agree with the pipeline registers being cleared in the same cycle.
   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_eff   = Rst ? ST_RUN : state_q;
      state_d     = ST_RUN;
      stall_cyc   = 1'b0;
      resolve_cyc = 1'b0;
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
      PCSrcBranch = 1'b0;
      case (state_eff)
         ST_RUN: begin
            if (ID_Branch) begin
               case (need)
                  NEED_TWO: begin stall_cyc = 1'b1; state_d = ST_HOLD;    end
                  NEED_ONE: begin stall_cyc = 1'b1; state_d = ST_RESOLVE; end
                  default:  resolve_cyc = 1'b1;
               endcase
            end else if (ID_Jump) begin
               IFID_Flush = 1'b1;
            end
         end
         ST_HOLD: begin
            stall_cyc = 1'b1;
            state_d   = ST_RESOLVE;
         end
         ST_RESOLVE: resolve_cyc = 1'b1;
         default:    state_d = ST_RUN;
      endcase
      if (stall_cyc) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
      if (resolve_cyc) begin
         IFID_Flush  = BranchTaken;
         PCSrcBranch = BranchTaken;
      end
   end

   // State register with synchronous reset to RUN.
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .Clk (Clk),
      .Rst (Rst),
      .Inc (resolve_cyc),
      .Q   (BranchCnt)
   );

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .Clk (Clk),
      .Rst (Rst),
      .Inc (resolve_cyc & BranchTaken),
      .Q   (TakenCnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .Clk (Clk),
      .Rst (Rst),
      .Inc (stall_cyc),
      .Q   (StallCnt)
   );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl. A second, 8-bit-counter instance
// shares all inputs so saturation can be reached in a few hundred cycles.
module tb_branch_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_branch, id_jump, id_uses_rt;
   logic [4:0]  id_rs, id_rt;
   logic        ex_regwrite, ex_memread;
   logic [4:0]  ex_writereg;
   logic        mem_memread;
   logic [4:0]  mem_writereg;
   logic        br_taken;

   logic        pc_write, ifid_write, idex_bubble, ifid_flush, pcsrc;
   logic [15:0] branch_cnt, taken_cnt, stall_cnt;
   logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_pcsrc;
   logic [7:0]  s_branch_cnt, s_taken_cnt, s_stall_cnt;
   logic [4:0]  ctl;

   int checks = 0;
   int errors = 0;

   // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, PCSrcBranch}
   localparam logic [4:0] CTL_IDLE  = 5'b11000;
   localparam logic [4:0] CTL_STALL = 5'b00100;
   localparam logic [4:0] CTL_TAKEN = 5'b11011;
   localparam logic [4:0] CTL_JUMP  = 5'b11010;

   assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, pcsrc};

   always #5 clk = ~clk;

   branch_hazard_ctrl dut (
      .Clk(clk), .Rst(rst), .ID_Branch(id_branch), .ID_Jump(id_jump),
      .ID_UsesRt(id_uses_rt), .ID_Rs(id_rs), .ID_Rt(id_rt),
      .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread), .EX_WriteReg(ex_writereg),
      .MEM_MemRead(mem_memread), .MEM_WriteReg(mem_writereg), .BranchTaken(br_taken),
      .PCWrite(pc_write), .IFID_Write(ifid_write), .IDEX_Bubble(idex_bubble),
      .IFID_Flush(ifid_flush), .PCSrcBranch(pcsrc),
      .BranchCnt(branch_cnt), .TakenCnt(taken_cnt), .StallCnt(stall_cnt)
   );

   branch_hazard_ctrl #(.CNT_W(8)) dut_small (
      .Clk(clk), .Rst(rst), .ID_Branch(id_branch), .ID_Jump(id_jump),
      .ID_UsesRt(id_uses_rt), .ID_Rs(id_rs), .ID_Rt(id_rt),
      .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread), .EX_WriteReg(ex_writereg),
      .MEM_MemRead(mem_memread), .MEM_WriteReg(mem_writereg), .BranchTaken(br_taken),
      .PCWrite(s_pc_write), .IFID_Write(s_ifid_write), .IDEX_Bubble(s_idex_bubble),
      .IFID_Flush(s_ifid_flush), .PCSrcBranch(s_pcsrc),
      .BranchCnt(s_branch_cnt), .TakenCnt(s_taken_cnt), .StallCnt(s_stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input int b, input int t, input int s);
      check({tag, " BranchCnt"}, {16'd0, branch_cnt}, b);
      check({tag, " TakenCnt"},  {16'd0, taken_cnt},  t);
      check({tag, " StallCnt"},  {16'd0, stall_cnt},  s);
   endtask

   // Move to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_branch = 0; id_jump = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
      ex_regwrite = 0; ex_memread = 0; ex_writereg = 0;
      mem_memread = 0; mem_writereg = 0; br_taken = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      do_reset();
      check("reset ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      check_cnt("reset", 0, 0, 0);

      // BEQ $3,$4 behind LW $3 in EX, taken: two stalls then redirect.
      id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 4;
      ex_memread = 1; ex_regwrite = 1; ex_writereg = 3; br_taken = 1;
      #1; check("lw stall1 ctl", {27'd0, ctl}, {27'd0, CTL_STALL});
      tick();
      ex_memread = 0; ex_regwrite = 0; ex_writereg = 0;   // HOLD ignores EX
      #1; check("lw stall2 ctl", {27'd0, ctl}, {27'd0, CTL_STALL});
      check("lw stall1 StallCnt", {16'd0, stall_cnt}, 1);
      tick();
      #1; check("lw resolve ctl", {27'd0, ctl}, {27'd0, CTL_TAKEN});
      tick();
      id_branch = 0;
      #1; check("lw after ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      check_cnt("lw", 1, 1, 2);

      // BNE $2,$4 behind ADD $4 in EX, not taken: one stall then resolve.
      do_reset();
      id_branch = 1; id_uses_rt = 1; id_rs = 2; id_rt = 4;
      ex_regwrite = 1; ex_writereg = 4; br_taken = 0;
      #1; check("alu stall ctl", {27'd0, ctl}, {27'd0, CTL_STALL});
      tick();
      #1; check("alu resolve ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      tick();
      id_branch = 0;
      #1; check_cnt("alu", 1, 0, 1);

      // BGTZ $5 with Rt=9 unused; ADD $9 in EX is no hazard.
      do_reset();
      id_branch = 1; id_uses_rt = 0; id_rs = 5; id_rt = 9;
      ex_regwrite = 1; ex_writereg = 9; br_taken = 1;
      #1; check("bgtz ctl", {27'd0, ctl}, {27'd0, CTL_TAKEN});
      tick();
      id_rs = 0; ex_writereg = 0; br_taken = 0;           // $0 writer, Rs=$0
      #1; check("r0 ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      tick();
      id_branch = 0; ex_regwrite = 0;
      #1; check_cnt("nodep", 2, 1, 0);

      // BEQ $7 behind LW $7 in MEM: one stall.
      id_branch = 1; id_uses_rt = 1; id_rs = 7; id_rt = 1;
      mem_memread = 1; mem_writereg = 7; br_taken = 0;
      #1; check("mem stall ctl", {27'd0, ctl}, {27'd0, CTL_STALL});
      tick();
      #1; check("mem resolve ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      tick();
      id_branch = 0; mem_memread = 0; mem_writereg = 0;
      #1; check_cnt("mem", 3, 1, 1);

      // Jump: flush only, front end keeps running.
      id_jump = 1;
      #1; check("jump ctl", {27'd0, ctl}, {27'd0, CTL_JUMP});
      tick();
      id_jump = 0;
      #1; check("jump after ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      check("jump BranchCnt", {16'd0, branch_cnt}, 3);

      // Illegal branch+jump: branch wins, not taken so no flush.
      id_branch = 1; id_jump = 1; id_rs = 6; id_rt = 6; br_taken = 0;
      #1; check("br+jump ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      tick();
      id_branch = 0; id_jump = 0;
      #1; check("br+jump BranchCnt", {16'd0, branch_cnt}, 4);

      // Reset asserted while in HOLD abandons the pending resolve.
      do_reset();
      id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 4;
      ex_memread = 1; ex_regwrite = 1; ex_writereg = 3; br_taken = 1;
      tick();
      id_branch = 0; rst = 1;
      #1; check("rst in hold ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      tick();
      rst = 0;
      #1; check("post rst ctl", {27'd0, ctl}, {27'd0, CTL_IDLE});
      check_cnt("post rst", 0, 0, 0);

      // Back-to-back load-use branches: 2 stalls + 1 resolve per 3 cycles.
      do_reset();
      id_branch = 1; id_uses_rt = 0; id_rs = 3;
      ex_memread = 1; ex_regwrite = 1; ex_writereg = 3; br_taken = 0;
      for (int i = 0; i < 390; i++) tick();
      check("sat small StallCnt",  {24'd0, s_stall_cnt},  255);
      check("sat small BranchCnt", {24'd0, s_branch_cnt}, 130);
      check("sat wide StallCnt",   {16'd0, stall_cnt},    260);
      for (int i = 0; i < 3; i++) tick();
      check("sat small hold",      {24'd0, s_stall_cnt},  255);
      check("sat wide StallCnt2",  {16'd0, stall_cnt},    262);
      check("sat wide BranchCnt",  {16'd0, branch_cnt},   131);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
